// File: rtl/cpu.sv
// rtl/cpu.sv - 16-bit stack CPU, four-phase instruction cycle.
// Define CPU_MUL_EN to build the multiplier; otherwise mul yields 0.
module cpu (
   input  logic        clk,
   input  logic        rst,
   output logic [9:0]  mem_addr,
   input  logic [15:0] rd_data,
   output logic [15:0] wr_data,
   output logic        mem_wr
);
   typedef enum logic [1:0] {
      PH_FETCH  = 2'd0,
      PH_DECODE = 2'd1,
      PH_EXEC   = 2'd2,
      PH_WB     = 2'd3
   } phase_t;

   typedef enum logic [2:0] {
      SA_NONE, SA_PUSH, SA_POP, SA_POP2, SA_NIP, SA_REPL
   } stk_act_t;

   phase_t      phase_q, phase_d;
   logic [9:0]  pc_q, pc_d;
   logic [15:0] insn_q, insn_d;
   logic [15:0] stack_q [16];
   logic [15:0] stack_d [16];
   logic [15:0] alu_out;
   logic        alu_ok;

   logic [7:0]  op, fn;
   logic [15:0] tos, nos, ld_val, mul_out, act_val;
   logic [9:0]  jmp_tgt;
   logic        is_push, is_ld, is_st, is_byte;
   stk_act_t    act;

   assign op      = insn_q[15:8];
   assign fn      = insn_q[7:0];
   assign tos     = stack_q[0];
   assign nos     = stack_q[1];
   assign is_push = ~insn_q[15];
   assign is_ld   = op inside {8'h90, 8'h91, 8'h98, 8'h99};
   assign is_st   = op inside {8'h94, 8'h95, 8'h96, 8'h9C, 8'h9D, 8'h9E};
   assign is_byte = op[3];
   assign jmp_tgt = pc_q + {insn_q[7], insn_q[7:0], 1'b0};
   assign ld_val  = !is_byte ? rd_data
                  : (tos[0] ? {8'h00, rd_data[15:8]} : {8'h00, rd_data[7:0]});

`ifdef CPU_MUL_EN
   assign mul_out = nos * tos;
`else
   assign mul_out = 16'h0000;
`endif

   always_comb begin
      alu_out = 16'h0000;
      alu_ok  = 1'b1;
      case (fn)
         8'h02:   alu_out = nos + tos;
         8'h03:   alu_out = nos - tos;
         8'h04:   alu_out = mul_out;
         8'h05:   alu_out = {nos[7:0], tos[7:0]};
         8'h08:   alu_out = {15'd0, $signed(nos) < $signed(tos)};
         8'h09:   alu_out = {15'd0, nos == tos};
         8'h0A:   alu_out = {15'd0, nos != tos};
         8'h10:   alu_out = nos & tos;
         8'h11:   alu_out = nos ^ tos;
         8'h12:   alu_out = nos | tos;
         8'h13:   alu_out = ~tos;
         default: alu_ok  = 1'b0;
      endcase
   end

   always_comb begin
      pc_d     = pc_q;
      insn_d   = insn_q;
      act      = SA_NONE;
      act_val  = tos;
      mem_addr = pc_q;
      wr_data  = is_byte ? {tos[7:0], tos[7:0]} : tos;
      mem_wr   = 1'b0;
      case (phase_q)
         PH_FETCH:  phase_d = PH_DECODE;
         PH_DECODE: phase_d = PH_EXEC;
         PH_EXEC:   phase_d = PH_WB;
         default:   phase_d = PH_FETCH;
      endcase
      case (phase_q)
         PH_DECODE: begin
            insn_d = rd_data;
            pc_d   = pc_q + 10'd2;
         end
         PH_EXEC: begin
            if (is_push) begin
               act     = SA_PUSH;
               act_val = {1'b0, insn_q[14:0]};
            end else if (is_ld) begin
               mem_addr = tos[9:0];
            end else if (is_st) begin
               // a store cycle seen together with rst is suppressed
               mem_addr = nos[9:0];
               mem_wr   = ~rst;
               case (op[1:0])
                  2'd0:    act = SA_POP2;
                  2'd1:    act = SA_POP;
                  default: act = SA_NIP;
               endcase
            end else begin
               case (op)
                  8'h81: act = SA_POP;
                  8'h82: act = SA_PUSH;
                  8'hA0: pc_d = jmp_tgt;
                  8'hA1: begin
                     act = SA_POP;
                     if (tos == 16'h0000) pc_d = jmp_tgt;
                  end
                  8'hA2: begin
                     act = SA_POP;
                     if (tos != 16'h0000) pc_d = jmp_tgt;
                  end
                  8'hB0: begin
                     if (alu_ok) act = (fn == 8'h13) ? SA_REPL : SA_NIP;
                     act_val = alu_out;
                  end
                  default: act = SA_NONE;
               endcase
            end
         end
         PH_WB: begin
            if (is_ld) act = op[0] ? SA_PUSH : SA_REPL;
            act_val = ld_val;
         end
         default: act = SA_NONE;
      endcase
   end

   // SA_NIP drops the two top entries and pushes act_val
   always_comb begin
      for (int i = 0; i < 16; i++) stack_d[i] = stack_q[i];
      case (act)
         SA_PUSH: begin
            stack_d[0] = act_val;
            for (int i = 1; i < 16; i++) stack_d[i] = stack_q[i-1];
         end
         SA_POP: begin
            for (int i = 0; i < 15; i++) stack_d[i] = stack_q[i+1];
            stack_d[15] = 16'h0000;
         end
         SA_POP2: begin
            for (int i = 0; i < 14; i++) stack_d[i] = stack_q[i+2];
            stack_d[14] = 16'h0000;
            stack_d[15] = 16'h0000;
         end
         SA_NIP: begin
            stack_d[0] = act_val;
            for (int i = 1; i < 15; i++) stack_d[i] = stack_q[i+1];
            stack_d[15] = 16'h0000;
         end
         SA_REPL: stack_d[0] = act_val;
         default: stack_d[0] = stack_q[0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= PH_FETCH;
         pc_q    <= 10'h200;
         insn_q  <= 16'h0000;
         for (int i = 0; i < 16; i++) stack_q[i] <= 16'h0000;
      end else begin
         phase_q <= phase_d;
         pc_q    <= pc_d;
         insn_q  <= insn_d;
         for (int i = 0; i < 16; i++) stack_q[i] <= stack_d[i];
      end
   end
endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - scoreboard bench for cpu: directed programs plus random programs
// checked against a queue-based interpreter of the instruction set.
module tb_cpu;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  mem_addr;
   logic [15:0] rd_data;
   logic [15:0] wr_data;
   logic        mem_wr;

   cpu dut (
      .clk      (clk),
      .rst      (rst),
      .mem_addr (mem_addr),
      .rd_data  (rd_data),
      .wr_data  (wr_data),
      .mem_wr   (mem_wr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [9:0]  a;
      logic [15:0] d;
   } st_t;

   logic [15:0] mem [512];
   logic [15:0] img [512];
   logic [15:0] prog [$];
   st_t         exp_q [$];
   st_t         mon_e;
   logic [15:0] mstk [$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          steps;

   logic [7:0] binops [10] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h08, 8'h09, 8'h0A, 8'h10, 8'h11, 8'h12};
   logic [7:0] stops  [6]  = '{8'h94, 8'h95, 8'h96, 8'h9C, 8'h9D, 8'h9E};
   logic [7:0] ldops  [4]  = '{8'h90, 8'h91, 8'h98, 8'h99};
   logic [15:0] undefs [12] = '{16'h8000, 16'h8300, 16'h9200, 16'h9700, 16'hA300, 16'hB100,
                                16'hC123, 16'hFFFF, 16'hB000, 16'hB006, 16'hB014, 16'hB0FF};

   // word-indexed memory; reloaded from img while rst is high
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 512; i++) mem[i] <= img[i];
      end else if (mem_wr) begin
         mem[mem_addr[9:1]] <= wr_data;
      end
      rd_data <= mem[mem_addr[9:1]];
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (!rst && mem_wr) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_store: mem_addr=%0h wr_data=%0h with none expected", mem_addr, wr_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("store_addr", 32'(mem_addr), 32'(mon_e.a));
            check("store_data", 32'(wr_data), 32'(mon_e.d));
         end
      end
   end

   task automatic emit(logic [15:0] w);
      prog.push_back(w);
   endtask

   task automatic push_lit(logic [14:0] v);
      emit({1'b0, v});
   endtask

   task automatic expect_st(logic [9:0] a, logic [15:0] d);
      exp_q.push_back({a, d});
   endtask

   function automatic logic [14:0] addr_lit();
      return 15'($urandom_range(0, 255) * 2);
   endfunction

   task automatic build_img();
      for (int i = 0; i < 256; i++) img[i] = 16'($urandom);
      for (int i = 0; i < 256; i++) img[256 + i] = (i < prog.size()) ? prog[i] : 16'hA0FF;
   endtask

   function automatic logic [15:0] mtop(int i);
      return (mstk.size() > i) ? mstk[i] : 16'h0000;
   endfunction

   function automatic void mpush(logic [15:0] v);
      mstk.push_front(v);
      if (mstk.size() > 16) void'(mstk.pop_back());
   endfunction

   function automatic void mpop();
      if (mstk.size() > 0) void'(mstk.pop_front());
   endfunction

   // Interpreter over the loaded image; stops at the self-loop jmp -1.
   task automatic model_run(output int n);
      logic [15:0] rm [512];
      logic [15:0] w, a, b, r, v;
      logic [9:0]  pc, ea;
      logic [7:0]  op, fn;
      bit          ok, taken;
      for (int i = 0; i < 512; i++) rm[i] = img[i];
      mstk.delete();
      pc = 10'h200;
      n = 0;
      while (n < 3000) begin
         w = rm[pc[9:1]];
         if (w == 16'hA0FF) break;
         n++;
         pc = pc + 10'd2;
         op = w[15:8];
         fn = w[7:0];
         a = mtop(1);
         b = mtop(0);
         if (!w[15]) mpush({1'b0, w[14:0]});
         else case (op)
            8'h81: mpop();
            8'h82: mpush(b);
            8'h90, 8'h91, 8'h98, 8'h99: begin
               v = rm[b[9:1]];
               if (op == 8'h98 || op == 8'h99) v = b[0] ? {8'h00, v[15:8]} : {8'h00, v[7:0]};
               if (op == 8'h90 || op == 8'h98) mpop();
               mpush(v);
            end
            8'h94, 8'h95, 8'h96, 8'h9C, 8'h9D, 8'h9E: begin
               ea = a[9:0];
               v = (op >= 8'h9C) ? {b[7:0], b[7:0]} : b;
               exp_q.push_back({ea, v});
               rm[ea[9:1]] = v;
               mpop();
               if (op != 8'h95 && op != 8'h9D) mpop();
               if (op == 8'h96 || op == 8'h9E) mpush(b);
            end
            8'hA0, 8'hA1, 8'hA2: begin
               if (op == 8'hA0) taken = 1'b1;
               else begin
                  mpop();
                  taken = (op == 8'hA1) ? (b == 16'h0000) : (b != 16'h0000);
               end
               if (taken) pc = 10'(int'(pc) + 2 * int'($signed(fn)));
            end
            8'hB0: begin
               ok = 1'b1;
               r = 16'h0000;
               case (fn)
                  8'h02: r = a + b;
                  8'h03: r = a - b;
`ifdef CPU_MUL_EN
                  8'h04: r = 16'(32'(a) * 32'(b));
`else
                  8'h04: r = 16'h0000;
`endif
                  8'h05: r = 16'((32'(a) << 8) | 32'(b[7:0]));
                  8'h08: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
                  8'h09: r = (a == b) ? 16'd1 : 16'd0;
                  8'h0A: r = (a != b) ? 16'd1 : 16'd0;
                  8'h10: r = a & b;
                  8'h11: r = a ^ b;
                  8'h12: r = a | b;
                  8'h13: r = ~b;
                  default: ok = 1'b0;
               endcase
               if (ok) begin
                  mpop();
                  if (fn != 8'h13) mpop();
                  mpush(r);
               end
            end
            default: ok = 1'b0;
         endcase
      end
   endtask

   task automatic operand();
      if ($urandom_range(0, 1) == 1) push_lit(15'($urandom));
      else begin
         push_lit(15'($urandom));
         push_lit(15'($urandom));
         emit(16'hB005);
      end
   endtask

   task automatic gen_random();
      logic [7:0] op;
      prog.delete();
      while (prog.size() < 220) begin
         case ($urandom_range(0, 3))
            0: begin
               push_lit(addr_lit());
               operand();
               operand();
               emit({8'hB0, binops[$urandom_range(0, 9)]});
               if ($urandom_range(0, 1) == 1) emit(16'hB013);
               op = stops[$urandom_range(0, 5)];
               emit({op, 8'h00});
               if (op[1:0] != 2'b00) emit(16'h8100);
            end
            1: begin
               push_lit(addr_lit());
               push_lit(15'($urandom_range(0, 511)));
               op = ldops[$urandom_range(0, 3)];
               emit({op, 8'h00});
               emit(16'h9400);
               if (op[0]) emit(16'h8100);
            end
            2: begin
               case ($urandom_range(0, 2))
                  0: push_lit(15'h0000);
                  1: push_lit(15'h0001);
                  default: push_lit(15'h0100);
               endcase
               op = 8'(8'hA0 + $urandom_range(0, 2));
               emit({op, 8'h03});
               push_lit(addr_lit());
               push_lit(15'($urandom));
               emit(16'h9400);
               if (op == 8'hA0) emit(16'h8100);
            end
            default: begin
               push_lit(addr_lit());
               operand();
               emit(undefs[$urandom_range(0, 11)]);
               emit(16'h8200);
               emit(16'hB002);
               emit(16'h9400);
            end
         endcase
      end
   endtask

   task automatic reset_cpu(bit chk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      if (chk) begin
         @(negedge clk);
         check("rst_mem_wr", 32'(mem_wr), 32'd0);
         check("rst_mem_addr", 32'(mem_addr), 32'h200);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      if (chk) begin
         @(negedge clk);
         check("first_fetch_addr", 32'(mem_addr), 32'h200);
      end
   endtask

   task automatic run_round(string name, int budget, bit chk);
      reset_cpu(chk);
      repeat (budget) @(posedge clk);
      @(negedge clk);
      check(name, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // add then store: 5+3 to address 2
      prog.delete();
      push_lit(15'h002); push_lit(15'h005); push_lit(15'h003); emit(16'hB002); emit(16'h9400);
      build_img();
      expect_st(10'h002, 16'h0008);
      run_round("drain_add_st", prog.size() * 4 + 16, 1'b1);

      // store then load back, word and ldd forms
      prog.delete();
      push_lit(15'h100); push_lit(15'h1234); emit(16'h9400);
      push_lit(15'h080); push_lit(15'h100); emit(16'h9000); emit(16'h9400);
      push_lit(15'h101); emit(16'h9100); emit(16'h9400);
      build_img();
      expect_st(10'h100, 16'h1234);
      expect_st(10'h080, 16'h1234);
      expect_st(10'h101, 16'h1234);
      run_round("drain_st_ld", prog.size() * 4 + 16, 1'b0);

      // jz taken skips two words, jz not taken falls through; depth probe via eq
      prog.delete();
      push_lit(15'h000); emit(16'hA102); push_lit(15'h050); push_lit(15'h999);
      push_lit(15'h001); emit(16'hA102); push_lit(15'h060); push_lit(15'h222); emit(16'h9400);
      push_lit(15'h000); emit(16'hB009); push_lit(15'h1F0); emit(16'h9500);
      build_img();
      expect_st(10'h060, 16'h0222);
      expect_st(10'h001, 16'h01F0);
      run_round("drain_jz", prog.size() * 4 + 16, 1'b0);

      // signed compare and add overflow
      prog.delete();
      push_lit(15'h010); push_lit(15'h003); push_lit(15'h007); emit(16'hB008); emit(16'h9400);
      push_lit(15'h012); push_lit(15'h7FFF); push_lit(15'h001); emit(16'hB002); emit(16'h9400);
      push_lit(15'h014); push_lit(15'h7FFF); push_lit(15'h001); emit(16'hB002);
      push_lit(15'h001); emit(16'hB008); emit(16'h9400);
      push_lit(15'h016); push_lit(15'h001); push_lit(15'h7FFF); push_lit(15'h001); emit(16'hB002);
      emit(16'hB008); emit(16'h9400);
      build_img();
      expect_st(10'h010, 16'h0001);
      expect_st(10'h012, 16'h8000);
      expect_st(10'h014, 16'h0001);
      expect_st(10'h016, 16'h0000);
      run_round("drain_lt", prog.size() * 4 + 16, 1'b0);

      // 17 pushes: deepest entry holds the 2nd value; 16 pops leave all zero
      prog.delete();
      for (int i = 1; i <= 17; i++) push_lit(15'(i));
      for (int i = 0; i < 15; i++) emit(16'h8100);
      push_lit(15'h002); emit(16'hB009); push_lit(15'h1E0); emit(16'h9500);
      for (int i = 0; i < 16; i++) emit(16'h8100);
      for (int i = 0; i < 15; i++) emit(16'hB012);
      push_lit(15'h000); emit(16'hB009); push_lit(15'h1E2); emit(16'h9500);
      build_img();
      expect_st(10'h001, 16'h01E0);
      expect_st(10'h001, 16'h01E2);
      run_round("drain_depth", prog.size() * 4 + 16, 1'b0);

      // byte store replicates low byte; byte and word loads read it back
      prog.delete();
      push_lit(15'h002); push_lit(15'h341); emit(16'h9C00);
      push_lit(15'h020); push_lit(15'h003); emit(16'h9800); emit(16'h9400);
      push_lit(15'h024); push_lit(15'h003); emit(16'h9000); emit(16'h9400);
      build_img();
      expect_st(10'h002, 16'h4141);
      expect_st(10'h020, 16'h0041);
      expect_st(10'h024, 16'h4141);
      run_round("drain_byte", prog.size() * 4 + 16, 1'b0);

      // rst asserted during the execute phase of a store suppresses it
      prog.delete();
      push_lit(15'h070); push_lit(15'h1555); emit(16'h9400);
      build_img();
      reset_cpu(1'b0);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("abort_mem_addr", 32'(mem_addr), 32'h070);
      check("abort_mem_wr", 32'(mem_wr), 32'd0);
      expect_st(10'h070, 16'h1555);
      run_round("drain_after_abort", prog.size() * 4 + 16, 1'b0);

      for (int r = 0; r < 6; r++) begin
         gen_random();
         build_img();
         model_run(steps);
         run_round("drain_random", steps * 4 + 20, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
